axi4_mem_responder: RTL and testbench
=====================================

Name: axi4_mem_responder

Overview:
- AXI4 slave with a 256-bit data path, backed by on-chip block RAM.
- Stands in for the MIG DDR3 controller so the AXI4 initiators (the DDR3 memory test, and later framebuffer/texture masters) can be run in simulation and on-board without DDR3 calibration.
- Presents the same port set and the same response semantics as the MIG AXI slave port, including per-byte write strobes, INCR bursts and error responses.

Parameters:
- ID_W, 4, width of AXI ID fields.
- ADDR_W, 30, byte address width.
- DATA_W, 256, data width; fixed at 256, giving 32 bytes per beat and AXSIZE = 3'b101.
- MEM_DEPTH, 1024, number of DATA_W words stored; word index = addr[ADDR_W-1:5].

Ports:
- ui_clk  in  1  single clock for all logic
- sys_rst_n  in  1  reset, asynchronous assert, active-low
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/ADDR_W/8/3/2  write address; awlock/awcache/awprot/awqos are accepted and ignored
- s_axi_awvalid in 1; s_axi_awready out 1
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1; s_axi_wready out 1
- s_axi_bid/bresp/bvalid  out  ID_W/2/1; s_axi_bready in 1
- s_axi_arid/araddr/arlen/arsize/arburst  in  same widths as the AW channel; arlock/arcache/arprot/arqos are ignored
- s_axi_arvalid in 1; s_axi_arready out 1
- s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1; s_axi_rready in 1

Behaviour:
- Reset (sys_rst_n=0, asynchronous):
  - Both FSMs go to IDLE.
  - bvalid, rvalid, rlast, bresp, rresp, bid, rid and rdata are all 0.
  - Memory contents are not cleared.
  - Reset during a burst aborts it; no B or R response is issued for the aborted burst.
- Ready signals:
  - awready = (wstate==W_IDLE). arready = (rstate==R_IDLE).
  - Both are 1 in the first cycle after reset is released.
- Write FSM:
  - W_IDLE: on awvalid&awready, latch awid, word index, beats = awlen+1, and error class; go to W_DATA.
  - W_DATA: wready=1. On each wvalid&wready:
    - If the beat is in range and the error class is OKAY, write each byte lane i where wstrb[i]=1.
    - Increment the word index (wraps modulo 2^(ADDR_W-5)) and decrement the beat count.
    - After the beats-th beat, go to W_RESP.
    - If wlast does not match "final beat", set SLVERR. The burst length is still taken from awlen, never from wlast.
  - W_RESP: bvalid=1, bid = latched ID, bresp = accumulated error. Hold until bready, then W_IDLE.
  - Throughput: one W beat per cycle; B is registered one cycle after the last W.
- Read FSM:
  - R_IDLE: on arvalid&arready, latch arid, index, beats and error class; go to R_FETCH.
  - R_FETCH: issue a synchronous RAM read (1-cycle latency); go to R_DATA.
  - R_DATA: rvalid=1. rdata is held stable until rready. rlast=1 on the final beat. rresp is per beat.
    - On handshake: if last, go to R_IDLE; else increment the index and go to R_FETCH.
  - Throughput: one R beat per 2 cycles, minimum.
- Error classes, evaluated per burst at address acceptance; SLVERR takes priority over DECERR:
  - SLVERR (2'b10): burst != INCR (2'b01), or size != 3'b101. Writes are discarded; reads return rdata=0.
  - DECERR (2'b11): evaluated per beat. Word index >= MEM_DEPTH means that beat's write is dropped; read beat returns rdata=0 with rresp=DECERR. bresp = DECERR if any beat was out of range.
  - OKAY (2'b00) otherwise.
- Addressing:
  - addr[4:0] is ignored; unaligned addresses are treated as aligned.
  - 4 KB boundary crossing is not checked.
- Channel interaction:
  - Write and read channels are independent and may be active concurrently.
  - Same-word write and read in the same cycle: the read returns the pre-write data (read-first).
- Outstanding transactions and ordering:
  - At most one outstanding write and one outstanding read.
  - No reordering; IDs are echoed unchanged.

Test Plan:
- Single-beat write, then read, to addr 0x40 with data {8{32'hA5A5_0001}} and wstrb all 1s -> bresp=00, bid=awid; R returns the same data with rresp=00, rlast=1.
- INCR awlen=3 at 0x100 with beats D0..D3, then arlen=3 read -> 4 R beats in order D0..D3; rlast only on beat 4; rid=arid=4'h5.
- Partial strobe: write all-FF, then wstrb=32'h0000_000F with data 0 -> readback has bytes 0-3 = 00 and bytes 4-31 = FF.
- Out of range: awaddr = MEM_DEPTH*32 -> bresp=11; read of the same address -> rdata=0, rresp=11. A burst of len=1 starting at the last valid word -> beat 0 OKAY, beat 1 DECERR.
- Error and backpressure:
  - awburst=2'b10 (WRAP) -> bresp=10 and memory unchanged.
  - bready/rready held low for 10 cycles -> bvalid/rvalid/rdata stay stable, and no new AW/AR is accepted.
- Reset mid-burst: deassert sys_rst_n during beat 2 of an awlen=7 write -> all outputs 0 immediately; after release, awready=1 and no bvalid is issued for the aborted burst.

Source files
------------

// File: rtl/axi4_mem_responder.sv
// AXI4 slave (256-bit) backed by on-chip RAM. It stands in for the MIG DDR3 AXI port,
// with byte strobes, INCR bursts and SLVERR/DECERR responses.
module axi4_mem_responder #(
  parameter int unsigned ID_W      = 4,
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic                  ui_clk,
  input  logic                  sys_rst_n,
  input  logic [ID_W-1:0]       s_axi_awid,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_W-1:0]       s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_W-1:0]       s_axi_arid,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_W-1:0]       s_axi_rid,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = ADDR_W - 5;
  localparam int unsigned RAM_AW = $clog2(MEM_DEPTH);
  localparam int unsigned BEAT_W = 9;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_e;

  wstate_e             wstate_q, wstate_d;
  logic [ID_W-1:0]     wid_q, wid_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [BEAT_W-1:0]   wbeats_q, wbeats_d;
  logic                wslv_q, wslv_d;
  logic [1:0]          werr_q, werr_d;
  logic [ID_W-1:0]     bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                bvalid_q, bvalid_d;
  logic                mem_we_c;

  rstate_e             rstate_q, rstate_d;
  logic [IDX_W-1:0]    ridx_q, ridx_d;
  logic [BEAT_W-1:0]   rbeats_q, rbeats_d;
  logic                rslv_q, rslv_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                rlast_q, rlast_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q;

  logic [DATA_W-1:0]   mem_q [MEM_DEPTH];

  logic w_in_range_c, r_in_range_c, w_final_c, rd_ok_c;
  logic unused_ok;

  assign w_in_range_c = widx_q < IDX_W'(MEM_DEPTH);
  assign r_in_range_c = ridx_q < IDX_W'(MEM_DEPTH);
  assign w_final_c    = (wbeats_q == BEAT_W'(1));
  assign rd_ok_c      = !rslv_q && r_in_range_c;

  assign s_axi_awready = (wstate_q == W_IDLE);
  assign s_axi_wready  = (wstate_q == W_DATA);
  assign s_axi_arready = (rstate_q == R_IDLE);
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;

  // Sideband AXI fields and the sub-word address bits have no effect on this memory
  assign unused_ok = ^{s_axi_awaddr[4:0], s_axi_araddr[4:0], s_axi_awlock, s_axi_awcache,
                       s_axi_awprot, s_axi_awqos, s_axi_arlock, s_axi_arcache,
                       s_axi_arprot, s_axi_arqos};

  // Write channel next state
  always_comb begin
    wstate_d = wstate_q;
    wid_d    = wid_q;
    widx_d   = widx_q;
    wbeats_d = wbeats_q;
    wslv_d   = wslv_q;
    werr_d   = werr_q;
    bid_d    = bid_q;
    bresp_d  = bresp_q;
    bvalid_d = bvalid_q;
    mem_we_c = 1'b0;
    case (wstate_q)
      W_IDLE: if (s_axi_awvalid) begin
        wid_d    = s_axi_awid;
        widx_d   = s_axi_awaddr[ADDR_W-1:5];
        wbeats_d = BEAT_W'(s_axi_awlen) + BEAT_W'(1);
        wslv_d   = (s_axi_awburst != 2'b01) || (s_axi_awsize != 3'b101);
        werr_d   = wslv_d ? RESP_SLVERR : RESP_OKAY;
        wstate_d = W_DATA;
      end
      W_DATA: if (s_axi_wvalid) begin
        mem_we_c = w_in_range_c && !wslv_q;
        if (!w_in_range_c && werr_q == RESP_OKAY) werr_d = RESP_DECERR;
        if (s_axi_wlast != w_final_c) werr_d = RESP_SLVERR;
        widx_d   = widx_q + IDX_W'(1);
        wbeats_d = wbeats_q - BEAT_W'(1);
        if (w_final_c) begin
          bvalid_d = 1'b1;
          bid_d    = wid_q;
          bresp_d  = werr_d;
          wstate_d = W_RESP;
        end
      end
      W_RESP: if (s_axi_bready) begin
        bvalid_d = 1'b0;
        wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  // Read channel next state; one beat per fetch/data pair
  always_comb begin
    rstate_d = rstate_q;
    ridx_d   = ridx_q;
    rbeats_d = rbeats_q;
    rslv_d   = rslv_q;
    rid_d    = rid_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    rvalid_d = rvalid_q;
    case (rstate_q)
      R_IDLE: if (s_axi_arvalid) begin
        rid_d    = s_axi_arid;
        ridx_d   = s_axi_araddr[ADDR_W-1:5];
        rbeats_d = BEAT_W'(s_axi_arlen) + BEAT_W'(1);
        rslv_d   = (s_axi_arburst != 2'b01) || (s_axi_arsize != 3'b101);
        rstate_d = R_FETCH;
      end
      R_FETCH: begin
        rvalid_d = 1'b1;
        rlast_d  = (rbeats_q == BEAT_W'(1));
        rresp_d  = rslv_q ? RESP_SLVERR : (r_in_range_c ? RESP_OKAY : RESP_DECERR);
        rstate_d = R_DATA;
      end
      R_DATA: if (s_axi_rready) begin
        rvalid_d = 1'b0;
        rlast_d  = 1'b0;
        if (rlast_q) begin
          rstate_d = R_IDLE;
        end else begin
          ridx_d   = ridx_q + IDX_W'(1);
          rbeats_d = rbeats_q - BEAT_W'(1);
          rstate_d = R_FETCH;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wstate_q <= W_IDLE;
      wid_q    <= '0;
      widx_q   <= '0;
      wbeats_q <= '0;
      wslv_q   <= 1'b0;
      werr_q   <= RESP_OKAY;
      bid_q    <= '0;
      bresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
      rstate_q <= R_IDLE;
      ridx_q   <= '0;
      rbeats_q <= '0;
      rslv_q   <= 1'b0;
      rid_q    <= '0;
      rresp_q  <= RESP_OKAY;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      wid_q    <= wid_d;
      widx_q   <= widx_d;
      wbeats_q <= wbeats_d;
      wslv_q   <= wslv_d;
      werr_q   <= werr_d;
      bid_q    <= bid_d;
      bresp_q  <= bresp_d;
      bvalid_q <= bvalid_d;
      rstate_q <= rstate_d;
      ridx_q   <= ridx_d;
      rbeats_q <= rbeats_d;
      rslv_q   <= rslv_d;
      rid_q    <= rid_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Byte-lane RAM write; contents deliberately survive reset
  always_ff @(posedge ui_clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (s_axi_wstrb[i]) mem_q[widx_q[RAM_AW-1:0]][i*8 +: 8] <= s_axi_wdata[i*8 +: 8];
      end
    end
  end

  // Synchronous read is read-first against a same-cycle write
  always_ff @(posedge ui_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdata_q <= '0;
    end else if (rstate_q == R_FETCH) begin
      rdata_q <= rd_ok_c ? mem_q[ridx_q[RAM_AW-1:0]] : '0;
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Scoreboard bench for axi4_mem_responder: stimulus pushes expected B/R responses,
// and a monitor pops and compares them on every handshake.
module tb_axi4_mem_responder;

  localparam logic [1:0] OKAY = 2'b00, SLV = 2'b10, DEC = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   awid = '0, arid = '0;
  logic [29:0]  awaddr = '0, araddr = '0;
  logic [7:0]   awlen = '0, arlen = '0;
  logic [2:0]   awsize = 3'b101, arsize = 3'b101;
  logic [1:0]   awburst = 2'b01, arburst = 2'b01;
  logic         awvalid = 1'b0, arvalid = 1'b0;
  logic [255:0] wdata = '0;
  logic [31:0]  wstrb = '0;
  logic         wlast = 1'b0, wvalid = 1'b0;
  logic         bready = 1'b1, rready = 1'b1;
  logic         awready, wready, bvalid, arready, rvalid, rlast;
  logic [3:0]   bid, rid;
  logic [1:0]   bresp, rresp;
  logic [255:0] rdata;

  always #5 clk = ~clk;

  axi4_mem_responder dut (
    .ui_clk(clk), .sys_rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awlock(1'b0), .s_axi_awcache(4'h3), .s_axi_awprot(3'b000),
    .s_axi_awqos(4'h0), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arlock(1'b0), .s_axi_arcache(4'h3), .s_axi_arprot(3'b000),
    .s_axi_arqos(4'h0), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct packed { logic [3:0] id; logic [255:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t b_q[$];
  r_exp_t r_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_data(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [255:0] beat_data(input logic [31:0] seed, input int k);
    return {8{seed + 32'(k)}};
  endfunction

  // Monitor: one handshake per falling edge where valid and ready are both high
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (b_q.size() == 0) begin
        fail_now("unexpected_b");
      end else begin
        b_exp_t e;
        e = b_q.pop_front();
        chk("b_id", 32'(bid), 32'(e.id));
        chk("b_resp", 32'(bresp), 32'(e.resp));
      end
    end
    if (rst_n && rvalid && rready) begin
      if (r_q.size() == 0) begin
        fail_now("unexpected_r");
      end else begin
        r_exp_t e;
        e = r_q.pop_front();
        chk("r_id", 32'(rid), 32'(e.id));
        chk_data("r_data", rdata, e.data);
        chk("r_resp", 32'(rresp), 32'(e.resp));
        chk("r_last", 32'(rlast), 32'(e.last));
      end
    end
  end

  task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
    b_exp_t e;
    e.id = id; e.resp = resp;
    b_q.push_back(e);
  endtask

  task automatic push_r(input logic [3:0] id, input logic [255:0] d, input logic [1:0] resp,
                        input logic last);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    r_q.push_back(e);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    bit got = 0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = size; awvalid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (awready) begin got = 1; break; end
    end
    if (!got) fail_now("aw_handshake");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [255:0] d, input logic [31:0] strb, input logic last);
    bit got = 0;
    wdata = d; wstrb = strb; wlast = last; wvalid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (wready) begin got = 1; break; end
    end
    if (!got) fail_now("w_handshake");
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input logic [2:0] size);
    bit got = 0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = size; arvalid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (arready) begin got = 1; break; end
    end
    if (!got) fail_now("ar_handshake");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [2:0] size, input logic [31:0] seed,
                          input logic [31:0] strb, input bit flip_last, input logic [1:0] exp_resp);
    push_b(id, exp_resp);
    send_aw(id, addr, len, burst, size);
    for (int k = 0; k <= int'(len); k++) send_w(beat_data(seed, k), strb, (k == int'(len)) ^ flip_last);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      if (b_q.size() == 0 && r_q.size() == 0) begin done = 1; break; end
    end
    if (!done) fail_now("drain_queues");
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [255:0] exp_d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_rvalid", 32'(rvalid), 0);
    chk("rst_rlast", 32'(rlast), 0);
    chk("rst_bresp", 32'(bresp), 0);
    chk("rst_rresp", 32'(rresp), 0);
    chk("rst_bid", 32'(bid), 0);
    chk("rst_rid", 32'(rid), 0);
    chk_data("rst_rdata", rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_awready", 32'(awready), 1);
    chk("post_rst_arready", 32'(arready), 1);
    @(posedge clk); #1;

    // Single beat write/read at 0x40
    do_write(4'h3, 30'h40, 8'd0, 2'b01, 3'b101, 32'hA5A5_0001, 32'hFFFF_FFFF, 0, OKAY);
    wait_idle();
    push_r(4'h3, {8{32'hA5A5_0001}}, OKAY, 1'b1);
    send_ar(4'h3, 30'h40, 8'd0, 2'b01, 3'b101);
    wait_idle();

    // Four-beat INCR burst at 0x100
    do_write(4'h5, 30'h100, 8'd3, 2'b01, 3'b101, 32'h1000_0000, 32'hFFFF_FFFF, 0, OKAY);
    wait_idle();
    for (int k = 0; k < 4; k++) push_r(4'h5, {8{32'h1000_0000 + 32'(k)}}, OKAY, k == 3);
    send_ar(4'h5, 30'h100, 8'd3, 2'b01, 3'b101);
    wait_idle();

    // Partial strobe over an all-ones word
    do_write(4'h1, 30'h200, 8'd0, 2'b01, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, OKAY);
    do_write(4'h1, 30'h200, 8'd0, 2'b01, 3'b101, 32'h0000_0000, 32'h0000_000F, 0, OKAY);
    wait_idle();
    exp_d = {{224{1'b1}}, 32'h0000_0000};
    push_r(4'h1, exp_d, OKAY, 1'b1);
    send_ar(4'h1, 30'h200, 8'd0, 2'b01, 3'b101);
    wait_idle();

    // Out of range, and a burst straddling the last valid word
    do_write(4'h6, 30'h8000, 8'd0, 2'b01, 3'b101, 32'h7777_0000, 32'hFFFF_FFFF, 0, DEC);
    wait_idle();
    push_r(4'h6, '0, DEC, 1'b1);
    send_ar(4'h6, 30'h8000, 8'd0, 2'b01, 3'b101);
    wait_idle();
    do_write(4'h7, 30'h7FE0, 8'd1, 2'b01, 3'b101, 32'h5555_0000, 32'hFFFF_FFFF, 0, DEC);
    wait_idle();
    push_r(4'h7, {8{32'h5555_0000}}, OKAY, 1'b0);
    push_r(4'h7, '0, DEC, 1'b1);
    send_ar(4'h7, 30'h7FE0, 8'd1, 2'b01, 3'b101);
    wait_idle();

    // WRAP write is rejected and leaves memory untouched; bad arsize and wlast are errors
    do_write(4'h8, 30'h40, 8'd0, 2'b10, 3'b101, 32'hDEAD_0000, 32'hFFFF_FFFF, 0, SLV);
    wait_idle();
    push_r(4'h8, {8{32'hA5A5_0001}}, OKAY, 1'b1);
    send_ar(4'h8, 30'h40, 8'd0, 2'b01, 3'b101);
    wait_idle();
    push_r(4'h9, '0, SLV, 1'b1);
    send_ar(4'h9, 30'h40, 8'd0, 2'b01, 3'b100);
    wait_idle();
    do_write(4'hA, 30'h500, 8'd1, 2'b01, 3'b101, 32'h0BAD_0000, 32'hFFFF_FFFF, 1, SLV);
    wait_idle();

    // B backpressure
    bready = 1'b0;
    do_write(4'h9, 30'h300, 8'd0, 2'b01, 3'b101, 32'h3030_0000, 32'hFFFF_FFFF, 0, OKAY);
    cnt = 0;
    while (!bvalid && cnt < 50) begin @(negedge clk); cnt++; end
    if (!bvalid) fail_now("bvalid_wait");
    repeat (10) begin
      @(negedge clk);
      chk("bp_bvalid", 32'(bvalid), 1);
      chk("bp_bid", 32'(bid), 32'h9);
      chk("bp_bresp", 32'(bresp), 0);
      chk("bp_awready", 32'(awready), 0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    wait_idle();

    // R backpressure
    rready = 1'b0;
    push_r(4'hB, {8{32'h3030_0000}}, OKAY, 1'b1);
    send_ar(4'hB, 30'h300, 8'd0, 2'b01, 3'b101);
    cnt = 0;
    while (!rvalid && cnt < 50) begin @(negedge clk); cnt++; end
    if (!rvalid) fail_now("rvalid_wait");
    repeat (10) begin
      @(negedge clk);
      chk("bp_rvalid", 32'(rvalid), 1);
      chk_data("bp_rdata", rdata, {8{32'h3030_0000}});
      chk("bp_arready", 32'(arready), 0);
    end
    @(posedge clk); #1;
    rready = 1'b1;
    wait_idle();

    // Reset during beat 2 of an eight-beat write
    send_aw(4'h2, 30'h400, 8'd7, 2'b01, 3'b101);
    send_w(beat_data(32'h4400_0000, 0), 32'hFFFF_FFFF, 1'b0);
    send_w(beat_data(32'h4400_0000, 1), 32'hFFFF_FFFF, 1'b0);
    wdata = beat_data(32'h4400_0000, 2); wlast = 1'b0; wvalid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", 32'(bvalid), 0);
    chk("mid_rst_rvalid", 32'(rvalid), 0);
    chk("mid_rst_wready", 32'(wready), 0);
    chk("mid_rst_bresp", 32'(bresp), 0);
    chk("mid_rst_bid", 32'(bid), 0);
    chk_data("mid_rst_rdata", rdata, '0);
    wvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_awready", 32'(awready), 1);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bvalid) cnt++;
    end
    chk("abort_no_bvalid", 32'(cnt), 0);
    @(posedge clk); #1;

    // Memory contents survive reset
    push_r(4'hC, {8{32'hA5A5_0001}}, OKAY, 1'b1);
    send_ar(4'hC, 30'h40, 8'd0, 2'b01, 3'b101);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
